rv32_icache_ctrl: RTL and testbench

Direct-mapped, read-only instruction cache controller between the CPU instruction-fetch port and the backing code memory. On a hit it returns the fetch word in the request cycle. On a miss it stalls the CPU, refills the whole line from the backing memory through a word-serial request/valid handshake, then serves the fetch. It also provides whole-cache invalidation for `fence.i` and hit/miss performance counters.

---
 rtl/rv32_icache_ctrl.sv | 154 +++++++++++++++
 tb/tb_rv32_icache_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32_icache_ctrl.sv
// ============================================================================
// Module   : rv32_icache_ctrl
// Brief    : Direct-mapped read-only instruction cache with word-serial refill
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv32_icache_ctrl #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   input  logic        inv_all,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_valid,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int WSEL   = $clog2(WORDS_PER_LINE);
   localparam int OFF    = WSEL + 2;
   localparam int IDX    = $clog2(LINES);
   localparam int TAGW   = 32 - OFF - IDX;
   localparam int LINE_W = 32 - OFF;
   localparam logic [WSEL-1:0] LAST_WORD = WSEL'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REFILL = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WSEL-1:0]     cnt_q, cnt_d;
   logic [LINE_W-1:0]   base_q, base_d;
   logic                inv_pend_q, inv_pend_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [31:0]         hit_count_q, hit_count_d;
   logic [31:0]         miss_count_q, miss_count_d;

   logic [TAGW-1:0]     tag_q  [LINES];
   logic [31:0]         data_q [LINES][WORDS_PER_LINE];

   logic [IDX-1:0]      req_idx;
   logic [TAGW-1:0]     req_tag;
   logic [WSEL-1:0]     req_word;
   logic [IDX-1:0]      ref_idx;
   logic [TAGW-1:0]     ref_tag;
   logic                hit;
   logic                unused_addr_bits;

   assign req_idx  = cpu_addr[OFF+IDX-1:OFF];
   assign req_tag  = cpu_addr[31:OFF+IDX];
   assign req_word = cpu_addr[OFF-1:2];
   assign unused_addr_bits = ^cpu_addr[1:0];

   // The refill target is kept as a line number; its low bits are the index.
   assign ref_idx = base_q[IDX-1:0];
   assign ref_tag = base_q[LINE_W-1:IDX];

   assign hit = cpu_req && (state_q == S_IDLE) && valid_q[req_idx]
                && (tag_q[req_idx] == req_tag);

   assign cpu_ready  = hit;
   assign cpu_rdata  = data_q[req_idx][req_word];
   assign mem_req    = (state_q == S_REFILL);
   assign mem_addr   = (state_q == S_REFILL) ? {base_q, cnt_q, 2'b00} : 32'd0;
   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      base_d       = base_q;
      inv_pend_d   = inv_pend_q;
      valid_d      = valid_q;
      hit_count_d  = hit_count_q + {31'd0, hit};
      miss_count_d = miss_count_q;
      if (inv_all) begin
         valid_d = '0;
      end
      case (state_q)
         S_IDLE: begin
            if (cpu_req && !hit) begin
               state_d          = S_REFILL;
               base_d           = cpu_addr[31:OFF];
               cnt_d            = '0;
               valid_d[req_idx] = 1'b0;
               miss_count_d     = miss_count_q + 32'd1;
            end
         end
         S_REFILL: begin
            if (inv_all) begin
               inv_pend_d = 1'b1;
            end
            if (mem_valid) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_WORD) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // An invalidate seen at any point of the refill leaves the line dead.
            valid_d[ref_idx] = !(inv_pend_q || inv_all);
            inv_pend_d       = 1'b0;
            state_d          = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         base_q       <= '0;
         inv_pend_q   <= 1'b0;
         valid_q      <= '0;
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         inv_pend_q   <= inv_pend_d;
         valid_q      <= valid_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   // Tag and data storage carries no reset; validity alone guards it.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == S_REFILL) && mem_valid) begin
         data_q[ref_idx][cnt_q] <= mem_rdata;
      end
      if (!rst && (state_q == S_DONE)) begin
         tag_q[ref_idx] <= ref_tag;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rv32_icache_ctrl.sv
// ============================================================================
// Module   : tb_rv32_icache_ctrl
// Brief    : Directed self-checking bench for rv32_icache_ctrl (default sizes)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rv32_icache_ctrl;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        inv_all;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int n_vec;
   int n_err;

   rv32_icache_ctrl #(
      .LINES          (16),
      .WORDS_PER_LINE (4)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .inv_all    (inv_all),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .mem_valid  (mem_valid),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   // Backing memory returns each word's own byte address as its contents.
   assign mem_rdata = mem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic do_reset();
      nxt();
      rst = 1'b1; cpu_req = 1'b0; inv_all = 1'b0; mem_valid = 1'b0;
      nxt();
      rst = 1'b0;
   endtask

   // One fetch; on a miss walks the whole refill with 'gap' wait cycles per word
   // and optionally pulses inv_all in refill cycle inv_cyc (1-based).
   task automatic do_fetch(input logic [31:0] a, input bit exp_hit,
                           input int gap, input int inv_cyc);
      logic [31:0] base;
      int c;
      base = a & 32'hFFFF_FFF0;
      nxt();
      cpu_req = 1'b1; cpu_addr = a; mem_valid = 1'b0; inv_all = 1'b0;
      #1;
      if (exp_hit) begin
         chk("hit_ready", {31'd0, cpu_ready}, 32'd1);
         chk("hit_rdata", cpu_rdata, a);
         chk("hit_no_mem_req", {31'd0, mem_req}, 32'd0);
         return;
      end
      chk("miss_ready", {31'd0, cpu_ready}, 32'd0);
      c = 0;
      for (int w = 0; w < 4; w++) begin
         for (int g = 0; g <= gap; g++) begin
            nxt();
            c++;
            mem_valid = (g == gap);
            inv_all   = (c == inv_cyc);
            #1;
            chk("refill_req", {31'd0, mem_req}, 32'd1);
            chk("refill_addr", mem_addr, base + 32'(4 * w));
         end
      end
      nxt();
      mem_valid = 1'b0; inv_all = 1'b0;
      if (inv_cyc != 0) cpu_req = 1'b0;
      #1;
      chk("done_req", {31'd0, mem_req}, 32'd0);
      chk("done_ready", {31'd0, cpu_ready}, 32'd0);
      nxt();
      #1;
      if (inv_cyc != 0) begin
         chk("inv_line_not_ready", {31'd0, cpu_ready}, 32'd0);
         chk("inv_idle_req", {31'd0, mem_req}, 32'd0);
      end else begin
         chk("post_fill_ready", {31'd0, cpu_ready}, 32'd1);
         chk("post_fill_rdata", cpu_rdata, a);
      end
   endtask

   task automatic chk_counts(input logic [31:0] h, input logic [31:0] m);
      nxt();
      cpu_req = 1'b0; inv_all = 1'b0; mem_valid = 1'b0;
      #1;
      chk("hit_count", hit_count, h);
      chk("miss_count", miss_count, m);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1; cpu_req = 1'b0; cpu_addr = 32'd0; inv_all = 1'b0; mem_valid = 1'b0;
      nxt(); nxt();
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_hits", hit_count, 32'd0);
      chk("rst_misses", miss_count, 32'd0);

      // Cold miss, then hits within the same line
      do_fetch(32'h4, 1'b0, 0, 0);
      chk_counts(32'd1, 32'd1);
      do_fetch(32'h0, 1'b1, 0, 0);
      do_fetch(32'h8, 1'b1, 0, 0);
      do_fetch(32'hC, 1'b1, 0, 0);
      chk_counts(32'd4, 32'd1);

      // Conflict eviction on index 0
      do_reset();
      do_fetch(32'h000, 1'b0, 0, 0);
      do_fetch(32'h100, 1'b0, 0, 0);
      do_fetch(32'h000, 1'b0, 0, 0);
      chk_counts(32'd3, 32'd3);

      // Wait states: valid every third cycle
      do_fetch(32'h40, 1'b0, 2, 0);
      chk_counts(32'd4, 32'd4);

      // Invalidate together with a request still hits on the old state
      nxt();
      cpu_req = 1'b1; cpu_addr = 32'h40; inv_all = 1'b1;
      #1;
      chk("inv_same_cycle_ready", {31'd0, cpu_ready}, 32'd1);
      chk("inv_same_cycle_rdata", cpu_rdata, 32'h40);
      do_fetch(32'h40, 1'b0, 0, 0);

      // Invalidate in IDLE
      do_fetch(32'h0, 1'b0, 0, 0);
      do_fetch(32'h0, 1'b1, 0, 0);
      nxt();
      cpu_req = 1'b0; inv_all = 1'b1;
      do_fetch(32'h0, 1'b0, 0, 0);

      // Invalidate during refill cycle 2
      do_fetch(32'h20, 1'b0, 0, 2);
      do_fetch(32'h20, 1'b0, 0, 0);
      chk_counts(32'd10, 32'd9);

      // Reset in refill cycle 2
      nxt();
      cpu_req = 1'b1; cpu_addr = 32'h80; mem_valid = 1'b0;
      #1;
      chk("rr_miss_ready", {31'd0, cpu_ready}, 32'd0);
      nxt();
      mem_valid = 1'b1;
      #1;
      chk("rr_addr1", mem_addr, 32'h80);
      nxt();
      rst = 1'b1;
      #1;
      chk("rr_addr2", mem_addr, 32'h84);
      nxt();
      rst = 1'b0; cpu_req = 1'b0; mem_valid = 1'b0;
      #1;
      chk("rr_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rr_hits", hit_count, 32'd0);
      chk("rr_misses", miss_count, 32'd0);
      do_fetch(32'h80, 1'b0, 0, 0);
      chk_counts(32'd1, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
